button_encoder: RTL and testbench
=================================

BUTTON_ENCODER -- requirements
Module: button_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, legal range 2..255: number of consecutive cycles a synchronized level must differ from the debounced level before the debounced level flips.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear of the output buffer, overflow flag and FSM.
REQ-005 SHALL have port btn  input  8  raw, asynchronous push-button levels; bit i is colour i; 1 means pressed.
REQ-006 SHALL have port code_ready  input  1  consumer accepts code this cycle.
REQ-007 SHALL have port code_valid  output  1  the buffer head holds a valid code.
REQ-008 SHALL have port code  output  3  index of the pressed button at the buffer head.
REQ-009 SHALL have port multi_press  output  1  one-cycle pulse when a press is rejected.
REQ-010 SHALL have port overflow  output  1  sticky flag set when a code is dropped because the buffer is full.

Function
REQ-011 SHALL pass each btn bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL give each bit its own debounce counter, 8 bits wide.
REQ-013 The counter SHALL clear on any cycle in which the synchronized level equals the debounced level.
REQ-014 The counter SHALL otherwise increment, and the debounced bit SHALL flip with the counter clearing on the edge where the counter equals DEBOUNCE_CYCLES-1.
REQ-015 SHALL define a press event as a debounced 0->1 transition of any bit; debounced 1->0 transitions are not events.
REQ-016 SHALL implement an FSM with states IDLE and HELD.
REQ-017 In IDLE, a press event with the new debounced vector one-hot SHALL push code = index of the set bit and go to HELD.
REQ-018 In IDLE, a press event with the new debounced vector not one-hot SHALL pulse multi_press for one cycle, push nothing and go to HELD.
REQ-019 In HELD, any press event SHALL pulse multi_press and push nothing.
REQ-020 In HELD, the FSM SHALL return to IDLE on the cycle after the debounced vector reads 8'h00.
REQ-021 Latency: for btn held stable high from the clock edge N that first samples it, code_valid SHALL be high after edge N+DEBOUNCE_CYCLES+2, provided the buffer was empty.
REQ-022 Handshake: a pop SHALL occur on an edge with code_valid and code_ready both high.
REQ-023 code and code_valid SHALL be stable while code_valid is high and code_ready is low.
REQ-024 A push into a full buffer SHALL drop the new code and set overflow.
REQ-025 A push and a pop on the same edge SHALL both take effect, so there is no overflow when full.
REQ-026 overflow SHALL remain set until clr or reset.
REQ-027 clr SHALL empty the buffer, drop code_valid and clear overflow on the next edge.
REQ-028 clr SHALL force the FSM to HELD, so a release is required before the next accept.
REQ-029 clr SHALL leave synchronizers and debounce state unchanged.
REQ-030 A push arriving on the same edge as clr SHALL be discarded.
REQ-031 code SHALL read 3'd0 whenever code_valid is low.

Reset
REQ-032 While rst_n is low: synchronizers, debounced vector and counters SHALL be 0; FSM SHALL be IDLE; buffer SHALL be empty.
REQ-033 While rst_n is low: code_valid=0, code=0, multi_press=0, overflow=0.
REQ-034 Deassertion SHALL take effect on the first clk edge with rst_n high.
REQ-035 Reset mid-debounce or mid-handshake SHALL discard all pending state; no code is emitted for a press already in progress until it is re-debounced from 0.

Configuration
REQ-036 With macro BUTTON_ENCODER_FIFO_EN defined, the output buffer SHALL be a 4-entry FIFO; codes pop in push order.
REQ-037 Without BUTTON_ENCODER_FIFO_EN, the output buffer SHALL be a single holding register; a second press before a pop sets overflow.
REQ-038 All other behaviour SHALL be identical in both configurations.

Verification (DEBOUNCE_CYCLES=4)
REQ-039 btn=8'h04 stable from edge 0, code_ready=1 -> code_valid high after edge 6 for exactly one cycle, code=3'd2.
REQ-040 btn bit0 toggling every 2 cycles for 20 cycles, then stable low -> no code_valid and no multi_press at any time.
REQ-041 btn=8'h81 rising together -> one multi_press pulse, no code_valid; after release and btn=8'h10 -> code=3'd4.
REQ-042 code_ready=0, five separate one-button presses 0,1,2,3,4 each released -> FIFO build: codes 0,1,2,3 held, overflow=1; non-FIFO build: code 0 held, overflow=1. Then code_ready=1 -> codes drain in order.
REQ-043 code_valid=1 with code_ready=0, then clr pulse -> code_valid=0 and overflow=0 next cycle; a still-held button gives no new code until released and pressed again.
REQ-044 rst_n pulsed low during the 3rd debounce cycle of btn=8'h02 -> all outputs 0; after release of rst_n with btn still high -> code=3'd1 after a full DEBOUNCE_CYCLES+2 edges.

Source files
------------

// File: rtl/button_encoder.sv
// Debounced 8-button colour encoder: press FSM plus an output code buffer.
// Define BUTTON_ENCODER_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] btn,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [2:0] code,
  output logic       multi_press,
  output logic       overflow
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0]      sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [7:0][7:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic            press_s, push_s, pop_s, ovf_push_s;
  logic            multi_d, multi_q, ovf_d, ovf_q;
  logic [2:0]      idx_s;

  // Synchronizers, debounce counters and the previous debounced vector; clr does not touch these
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      deb_q      <= 8'h00;
      deb_prev_q <= 8'h00;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'h00;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = 8'h00;
        deb_d[i] = ~deb_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'h01;
      end
    end
  end

  // Encoder is only consumed when deb_q is one-hot, so an OR-reduction per index bit suffices
  assign idx_s[0] = |(deb_q & 8'hAA);
  assign idx_s[1] = |(deb_q & 8'hCC);
  assign idx_s[2] = |(deb_q & 8'hF0);
  assign press_s  = |(deb_q & ~deb_prev_q);

  // Press FSM state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      multi_q <= multi_d;
      ovf_q   <= ovf_d;
    end
  end

  // Accept a lone press from IDLE, reject anything else; clr parks the FSM in HELD
  always_comb begin
    state_d = state_q;
    push_s  = 1'b0;
    multi_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_s) begin
          state_d = HELD;
          if ($onehot(deb_q)) begin
            push_s = 1'b1;
          end else begin
            multi_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (press_s) begin
          multi_d = 1'b1;
        end else if (deb_q == 8'h00) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d = HELD;
      end
    endcase
    if (clr) begin
      state_d = HELD;
      push_s  = 1'b0;
      multi_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Sticky overflow, cleared only by clr or reset
  always_comb begin
    if (clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | ovf_push_s;
    end
  end

`ifdef BUTTON_ENCODER_FIFO_EN
  logic [3:0][2:0] mem_q;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      fcnt_q;
  logic            full_s, wr_s;

  assign full_s     = (fcnt_q == 3'd4);
  assign pop_s      = (fcnt_q != 3'd0) & code_ready;
  assign wr_s       = push_s & (~full_s | pop_s);
  assign ovf_push_s = push_s & full_s & ~pop_s;

  // 4-entry FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wr_q   <= 2'd0;
      rd_q   <= 2'd0;
      fcnt_q <= 3'd0;
    end else if (clr) begin
      wr_q   <= 2'd0;
      rd_q   <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      if (wr_s) begin
        mem_q[wr_q] <= idx_s;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop_s) begin
        rd_q <= rd_q + 2'd1;
      end
      fcnt_q <= fcnt_q + {2'b00, wr_s} - {2'b00, pop_s};
    end
  end

  // Head of FIFO, forced to zero when empty
  always_comb begin
    code_valid = (fcnt_q != 3'd0);
    if (code_valid) begin
      code = mem_q[rd_q];
    end else begin
      code = 3'd0;
    end
  end
`else
  logic [2:0] hold_q;
  logic       full_q;

  assign pop_s      = full_q & code_ready;
  assign ovf_push_s = push_s & full_q & ~pop_s;

  // Single holding register; a simultaneous pop frees the slot for the new code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 3'd0;
      full_q <= 1'b0;
    end else if (clr) begin
      full_q <= 1'b0;
    end else if (push_s && (!full_q || pop_s)) begin
      hold_q <= idx_s;
      full_q <= 1'b1;
    end else if (pop_s) begin
      full_q <= 1'b0;
    end
  end

  // Holding register output, forced to zero when empty
  always_comb begin
    code_valid = full_q;
    if (full_q) begin
      code = hold_q;
    end else begin
      code = 3'd0;
    end
  end
`endif

  assign multi_press = multi_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder (DEBOUNCE_CYCLES=4) against a queue-based reference model.
module tb_button_encoder;
  localparam int D = 4;
`ifdef BUTTON_ENCODER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       code_ready = 1'b0;
  logic [7:0] btn = 8'h00;
  logic       code_valid, multi_press, overflow;
  logic [2:0] code;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .btn(btn), .code_ready(code_ready),
    .code_valid(code_valid), .code(code), .multi_press(multi_press), .overflow(overflow)
  );

  wire [5:0] obs_vec = {code_valid, code, multi_press, overflow};

  // Reference model: sampled level delayed two cycles, run-length debounce, code queue
  logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00, m_deb = 8'h00, m_pdeb = 8'h00;
  int         m_run[8];
  bit         m_held = 1'b0, m_ovf = 1'b0, m_mp = 1'b0;
  int         m_q[$];
  logic [5:0] exp_vec = 6'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_deb = 8'h00; m_pdeb = 8'h00;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_held = 1'b0; m_ovf = 1'b0; m_mp = 1'b0;
      m_q.delete();
    end else begin : step
      bit press, push, rej, pop;
      int c;
      press = |(m_deb & ~m_pdeb);
      push = 1'b0; rej = 1'b0; c = 0;
      if (press) begin
        if (!m_held && $countones(m_deb) == 1) push = 1'b1;
        else rej = 1'b1;
      end
      pop = (m_q.size() > 0) && code_ready;
      if (clr) begin
        m_q.delete(); m_ovf = 1'b0; m_mp = 1'b0; m_held = 1'b1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          for (int i = 0; i < 8; i++) if (m_deb[i]) c = i;
          if (m_q.size() < CAP) m_q.push_back(c);
          else m_ovf = 1'b1;
        end
        m_mp = rej;
        if (!m_held) m_held = press;
        else if (m_deb == 8'h00) m_held = 1'b0;
      end
      m_pdeb = m_deb;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_deb[i] = ~m_deb[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    exp_vec = (m_q.size() > 0) ? {1'b1, 3'(m_q[0]), m_mp, m_ovf} : {4'b0000, m_mp, m_ovf};
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== 6'd0) begin n_bad++; $display("FAIL reset: got %b want %b", obs_vec, 6'd0); end
    end
    btn = 8'h00;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    code_ready = 1'b1;
    btn = 8'h04;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (code_valid !== ((k == 6) ? 1'b1 : 1'b0) || code !== ((k == 6) ? 3'd2 : 3'd0)) begin
        n_bad++; $display("FAIL latency edge %0d: got v=%b c=%0d want v=%b c=%0d", k, code_valid, code, (k == 6), (k == 6) ? 2 : 0);
      end
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL latency_model: got %b want %b", obs_vec, exp_vec); end
    end
    btn = 8'h00;
    idle(12);
  endtask

  task automatic test_bounce();
    code_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      btn = (k < 20 && ((k / 2) % 2 == 0)) ? 8'h01 : 8'h00;
      @(negedge clk);
      n_cmp++;
      if (code_valid !== 1'b0 || multi_press !== 1'b0) begin
        n_bad++; $display("FAIL bounce cycle %0d: got v=%b mp=%b want 0 0", k, code_valid, multi_press);
      end
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL bounce_model: got %b want %b", obs_vec, exp_vec); end
    end
  endtask

  task automatic test_multi();
    int mp_cnt;
    bit seen;
    logic [2:0] got;
    mp_cnt = 0; seen = 1'b0; got = 3'd0;
    code_ready = 1'b1;
    btn = 8'h81;
    repeat (12) begin
      @(negedge clk);
      if (multi_press === 1'b1) mp_cnt++;
      n_cmp++;
      if (code_valid !== 1'b0) begin n_bad++; $display("FAIL multi_valid: got %b want 0", code_valid); end
    end
    n_cmp++;
    if (mp_cnt != 1) begin n_bad++; $display("FAIL multi_pulses: got %0d want 1", mp_cnt); end
    btn = 8'h00;
    idle(12);
    btn = 8'h10;
    repeat (10) begin
      @(negedge clk);
      if (code_valid === 1'b1) begin seen = 1'b1; got = code; end
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL multi_model: got %b want %b", obs_vec, exp_vec); end
    end
    n_cmp++;
    if (!seen || got !== 3'd4) begin n_bad++; $display("FAIL multi_code: got seen=%b code=%0d want 1 4", seen, got); end
    btn = 8'h00;
    idle(12);
  endtask

  task automatic test_overflow();
    int got[$];
    int want[$];
    code_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      btn = 8'(1 << p);
      repeat (9) begin
        @(negedge clk);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL ovf_model: got %b want %b", obs_vec, exp_vec); end
      end
      btn = 8'h00;
      idle(10);
    end
    n_cmp++;
    if (code_valid !== 1'b1 || code !== 3'd0 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_hold: got v=%b c=%0d o=%b want 1 0 1", code_valid, code, overflow);
    end
    code_ready = 1'b1;
    repeat (8) begin
      if (code_valid === 1'b1) got.push_back(int'(code));
      @(negedge clk);
    end
    for (int i = 0; i < CAP; i++) want.push_back(i);
    n_cmp++;
    if (got.size() != want.size()) begin n_bad++; $display("FAIL drain_count: got %0d want %0d", got.size(), want.size()); end
    for (int i = 0; i < got.size() && i < want.size(); i++) begin
      n_cmp++;
      if (got[i] != want[i]) begin n_bad++; $display("FAIL drain_order %0d: got %0d want %0d", i, got[i], want[i]); end
    end
    n_cmp++;
    if (overflow !== 1'b1 || code_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_sticky: got o=%b v=%b want 1 0", overflow, code_valid); end
  endtask

  task automatic test_clr();
    code_ready = 1'b0;
    btn = 8'h08;
    idle(10);
    n_cmp++;
    if (code_valid !== 1'b1 || code !== 3'd3) begin n_bad++; $display("FAIL clr_pre: got v=%b c=%0d want 1 3", code_valid, code); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if (code_valid !== 1'b0 || overflow !== 1'b0 || code !== 3'd0) begin
      n_bad++; $display("FAIL clr_post: got v=%b o=%b c=%0d want 0 0 0", code_valid, overflow, code);
    end
    repeat (15) begin
      @(negedge clk);
      n_cmp++;
      if (code_valid !== 1'b0) begin n_bad++; $display("FAIL clr_held: got %b want 0", code_valid); end
    end
    btn = 8'h00;
    idle(12);
    btn = 8'h08;
    idle(10);
    n_cmp++;
    if (code_valid !== 1'b1 || code !== 3'd3) begin n_bad++; $display("FAIL clr_repress: got v=%b c=%0d want 1 3", code_valid, code); end
    code_ready = 1'b1;
    btn = 8'h00;
    idle(12);
  endtask

  task automatic test_reset_mid();
    code_ready = 1'b1;
    btn = 8'h02;
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_vec !== 6'd0) begin n_bad++; $display("FAIL rst_mid: got %b want %b", obs_vec, 6'd0); end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (code_valid !== ((k == 6) ? 1'b1 : 1'b0) || code !== ((k == 6) ? 3'd1 : 3'd0)) begin
        n_bad++; $display("FAIL rst_relatch edge %0d: got v=%b c=%0d want v=%b", k, code_valid, code, (k == 6));
      end
    end
    btn = 8'h00;
    idle(12);
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 2500; k++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: btn = 8'h00;
          5, 6, 7:       btn = 8'(1 << $urandom_range(0, 7));
          8:             btn = 8'($urandom);
          default:       btn = btn ^ 8'(1 << $urandom_range(0, 7));
        endcase
        hold = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      code_ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL random cycle %0d: got %b want %b", k, obs_vec, exp_vec); end
    end
    clr = 1'b0;
    btn = 8'h00;
    idle(12);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_bounce();
    test_multi();
    test_overflow();
    test_clr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
